// File: rtl/ss_seq_engine_pkg.sv
// Shared definitions for the mapper save-state initiator: FSM encoding, bank codes and
// default image geometry.
`timescale 1ns/1ps
package ss_seq_engine_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSetup,
        StRdWait,
        StMemWr,
        StMemRd,
        StM2Wait,
        StM2Hold,
        StNext,
        StDone
    } ss_state_e;

    localparam logic [7:0] SS_BANK_REG  = 8'd0;
    localparam logic [7:0] SS_BANK_XRAM = 8'd1;

    localparam int unsigned SS_REG_LEN    = 128;
    localparam int unsigned SS_XRAM_LEN   = 1024;
    localparam int unsigned SS_RD_LAT     = 2;
    localparam int unsigned SS_M2_TIMEOUT = 255;
    localparam int unsigned SS_RO_IDX     = 127;

    // Strobe-on cycles before an m2 fall is trusted: a pulse seen earlier may come from an
    // edge that happened before the strobe rose (synchroniser + edge register lag).
    localparam int unsigned SS_M2_ARM = 3;

    function automatic logic [10:0] ss_mem_addr(input logic bank, input logic [9:0] addr);
        return {bank, addr};
    endfunction

endpackage

// File: rtl/ss_seq_engine_m2_edge_sync.sv
// Brings the asynchronous CPU m2 clock into the clk domain and flags its falling edges
// with a one-cycle pulse.
`timescale 1ns/1ps
module m2_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic m2_i,
    output logic m2_fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], m2_i};
            prev_q <= sync_q[1];
        end
    end

    assign m2_fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/ss_seq_engine.sv
// Save-state initiator: walks the mapper register page and ExRAM, copying bytes to the
// external state buffer on save and writing them back into the mapper on restore.
`timescale 1ns/1ps
module ss_seq_engine
    import ss_seq_engine_pkg::*;
#(
    parameter int unsigned REG_LEN    = SS_REG_LEN,
    parameter int unsigned XRAM_LEN   = SS_XRAM_LEN,
    parameter int unsigned RD_LAT     = SS_RD_LAT,
    parameter int unsigned M2_TIMEOUT = SS_M2_TIMEOUT,
    parameter int unsigned RO_IDX     = SS_RO_IDX
) (
    input  logic        clk,
    input  logic        map_rst,
    input  logic        start,
    input  logic        dir,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        m2,
    output logic        ss_act,
    output logic [7:0]  ss_bank1KB,
    output logic [9:0]  ss_addr,
    output logic        ss_we,
    output logic        ss_wr_req,
    output logic [7:0]  ss_wdat,
    input  logic [7:0]  ss_rdat,
    output logic        mem_req,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [7:0]  mem_wdat,
    input  logic [7:0]  mem_rdat,
    input  logic        mem_ack
);

    localparam int unsigned CntMax = (M2_TIMEOUT > RD_LAT) ? M2_TIMEOUT : RD_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    ss_state_e       state_q, state_d;
    logic            dir_q, dir_d;
    logic            err_q, err_d;
    logic            bank_q, bank_d;
    logic [9:0]      addr_q, addr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      wdat_q, wdat_d;
    logic [7:0]      mem_wdat_q, mem_wdat_d;

    logic            m2_fall;
    logic            strobe;
    logic [9:0]      page_last;

    m2_edge_sync u_m2_sync (
        .clk_i     (clk),
        .rst_i     (map_rst),
        .m2_i      (m2),
        .m2_fall_o (m2_fall)
    );

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state_q    <= StIdle;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            bank_q     <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            wdat_q     <= '0;
            mem_wdat_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wdat_q     <= wdat_d;
            mem_wdat_q <= mem_wdat_d;
        end
    end

    assign page_last = bank_q ? 10'(XRAM_LEN - 1) : 10'(REG_LEN - 1);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        err_d      = err_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wdat_d     = wdat_q;
        mem_wdat_d = mem_wdat_q;
        strobe     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dir_d   = dir;
                    err_d   = 1'b0;
                    bank_d  = 1'b0;
                    addr_d  = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (dir_q) begin
                    state_d = StMemRd;
                end else begin
                    cnt_d   = CntW'(RD_LAT);
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (cnt_q == '0) begin
                    mem_wdat_d = ss_rdat;
                    state_d    = StMemWr;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    state_d = StNext;
                end
            end
            StMemRd: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wdat_d = mem_rdat;
                    if (!bank_q && addr_q == 10'(RO_IDX)) begin
                        state_d = StNext;
                    end else begin
                        cnt_d   = '0;
                        state_d = StM2Wait;
                    end
                end
            end
            StM2Wait: begin
                // First cycle lets ss_wdat settle before the strobe goes up.
                strobe = (cnt_q != '0);
                if (m2_fall && cnt_q >= CntW'(SS_M2_ARM)) begin
                    state_d = StM2Hold;
                end else if (cnt_q == CntW'(M2_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StM2Hold: begin
                strobe  = 1'b1;
                state_d = StNext;
            end
            StNext: begin
                state_d = StSetup;
                if (addr_q == page_last) begin
                    if (!bank_q) begin
                        bank_d = 1'b1;
                        addr_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign ss_act     = busy;
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign ss_bank1KB = bank_q ? SS_BANK_XRAM : SS_BANK_REG;
    assign ss_addr    = addr_q;
    assign ss_we      = strobe & ~bank_q;
    assign ss_wr_req  = strobe & bank_q;
    assign ss_wdat    = wdat_q;
    assign mem_addr   = ss_mem_addr(bank_q, addr_q);
    assign mem_wdat   = mem_wdat_q;

endmodule

// File: tb/tb_ss_seq_engine.sv
// Directed bench for ss_seq_engine: mapper and buffer models, scoreboards for saved and
// restored bytes, plus a second instance with a slower mapper read latency.
`timescale 1ns/1ps
module tb_ss_seq_engine;
    import ss_seq_engine_pkg::*;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // m2 period 120 ns = 12 clk, edges 3 ns after a negedge so never on a clk edge.
    logic m2 = 1'b1;
    bit   m2_run = 1'b1;
    initial begin
        #3;
        forever begin
            #60;
            m2 = m2_run ? ~m2 : 1'b1;
        end
    end

    logic        map_rst, start, dir;
    logic        busy, done, err, ss_act, ss_we, ss_wr_req, mem_req, mem_we, mem_ack;
    logic [7:0]  ss_bank1KB, ss_wdat, ss_rdat, mem_wdat;
    logic [7:0]  mem_rdat = 8'h00;
    logic [9:0]  ss_addr;
    logic [10:0] mem_addr;

    ss_seq_engine u_dut (
        .clk        (clk),
        .map_rst    (map_rst),
        .start      (start),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .m2         (m2),
        .ss_act     (ss_act),
        .ss_bank1KB (ss_bank1KB),
        .ss_addr    (ss_addr),
        .ss_we      (ss_we),
        .ss_wr_req  (ss_wr_req),
        .ss_wdat    (ss_wdat),
        .ss_rdat    (ss_rdat),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdat   (mem_wdat),
        .mem_rdat   (mem_rdat),
        .mem_ack    (mem_ack)
    );

    // Mapper read model: data valid only once the address has been stable RD_LAT cycles.
    logic [17:0] prev1 = '0;
    int          st1 = 0;
    always @(negedge clk) begin
        if ({ss_bank1KB, ss_addr} != prev1) st1 = 0;
        else if (st1 < 1000) st1++;
        prev1 = {ss_bank1KB, ss_addr};
    end
    assign ss_rdat = (st1 >= 2) ? {ss_bank1KB[0], ss_addr[6:0]} : ~{ss_bank1KB[0], ss_addr[6:0]};

    logic [7:0]  mem_buf [2048];
    logic [18:0] save_sb [$];
    logic [18:0] rest_sb [$];
    logic        ack_q = 1'b0;
    logic        stray_ack = 1'b0;
    int          mem_wr_cnt = 0, mem_rd_cnt = 0, unexp_mem = 0;
    assign mem_ack = ack_q | stray_ack;

    always @(negedge clk) begin
        if (ack_q) begin
            ack_q = 1'b0;
        end else if (mem_req) begin
            ack_q = 1'b1;
            if (mem_we) begin
                mem_buf[mem_addr] = mem_wdat;
                mem_wr_cnt++;
                if (save_sb.size() == 0) unexp_mem++;
                else check("save_byte", 32'({mem_addr, mem_wdat}), 32'(save_sb.pop_front()));
            end else begin
                mem_rdat = mem_buf[mem_addr];
                mem_rd_cnt++;
            end
        end
    end

    // Mapper write model: a write lands on every m2 fall seen with a strobe up.
    logic [7:0] map_reg  [128];
    logic [7:0] map_xram [1024];
    int         map_wr_cnt = 0, unexp_map = 0;
    always @(negedge m2) begin
        if (ss_we || ss_wr_req) begin
            map_wr_cnt++;
            if (ss_we) map_reg[ss_addr[6:0]] = ss_wdat;
            else map_xram[ss_addr] = ss_wdat;
            if (rest_sb.size() == 0) unexp_map++;
            else check("restore_byte", 32'({ss_wr_req, ss_addr, ss_wdat}), 32'(rest_sb.pop_front()));
        end
    end

    // Strobe/handshake monitor: each strobe interval must contain exactly one m2 fall.
    logic stb_prev = 1'b0;
    int   stb_cnt = 0, bad_span = 0, both_hi = 0, done_cnt = 0, bad_act = 0, rise_wr = 0;
    always @(negedge clk) begin
        if (ss_we && ss_wr_req) both_hi++;
        if (done) done_cnt++;
        if (done && ss_act) bad_act++;
        if ((ss_we || ss_wr_req) && !stb_prev) begin
            stb_cnt++;
            rise_wr = map_wr_cnt;
        end
        if (!(ss_we || ss_wr_req) && stb_prev && map_wr_cnt != rise_wr + 1) bad_span++;
        stb_prev = ss_we || ss_wr_req;
    end

    // Second instance with a slower mapper.
    logic        start2, busy2, done2, err2, ss_act2, ss_we2, ss_wr_req2, mem_req2, mem_we2;
    logic        ack2 = 1'b0;
    logic [7:0]  ss_bank1KB2, ss_wdat2, ss_rdat2, mem_wdat2;
    logic [9:0]  ss_addr2;
    logic [10:0] mem_addr2;
    logic [17:0] prev2 = '0;
    int          st2 = 0, idx2 = 0, done2_cnt = 0, bad2 = 0;

    ss_seq_engine #(.RD_LAT(4)) u_dut2 (
        .clk        (clk),
        .map_rst    (map_rst),
        .start      (start2),
        .dir        (1'b0),
        .busy       (busy2),
        .done       (done2),
        .err        (err2),
        .m2         (1'b1),
        .ss_act     (ss_act2),
        .ss_bank1KB (ss_bank1KB2),
        .ss_addr    (ss_addr2),
        .ss_we      (ss_we2),
        .ss_wr_req  (ss_wr_req2),
        .ss_wdat    (ss_wdat2),
        .ss_rdat    (ss_rdat2),
        .mem_req    (mem_req2),
        .mem_we     (mem_we2),
        .mem_addr   (mem_addr2),
        .mem_wdat   (mem_wdat2),
        .mem_rdat   (8'h00),
        .mem_ack    (ack2)
    );

    assign ss_rdat2 = (st2 >= 4) ? {ss_bank1KB2[0], ss_addr2[6:0]} : ~{ss_bank1KB2[0], ss_addr2[6:0]};

    always @(negedge clk) begin
        if ({ss_bank1KB2, ss_addr2} != prev2) st2 = 0;
        else if (st2 < 1000) st2++;
        prev2 = {ss_bank1KB2, ss_addr2};
        if (done2) done2_cnt++;
        if (ss_we2 || ss_wr_req2 || err2 || (done2 && ss_act2) || (busy2 && !ss_act2)) bad2++;
        if (ack2) begin
            ack2 = 1'b0;
        end else if (mem_req2) begin
            ack2 = 1'b1;
            check("lat4_addr", 32'({mem_we2, mem_addr2}),
                  32'({1'b1, (idx2 < 128) ? 11'(idx2) : 11'(1024 + idx2 - 128)}));
            check("lat4_byte", 32'(mem_wdat2), 32'({mem_addr2[10], mem_addr2[6:0]}));
            idx2++;
        end
    end

    int b_wr, b_rd, b_map, b_stb, b_span, b_done, b_both, b_act;
    task automatic snap();
        b_wr = mem_wr_cnt; b_rd = mem_rd_cnt; b_map = map_wr_cnt; b_stb = stb_cnt;
        b_span = bad_span; b_done = done_cnt; b_both = both_hi; b_act = bad_act;
    endtask

    task automatic pulse_start(input logic d);
        @(negedge clk);
        start = 1'b1;
        dir   = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({busy, done, err, ss_act, ss_we, ss_wr_req, mem_req, mem_we}), 0);
        check(tag, 32'({ss_bank1KB, ss_addr, mem_addr}), 0);
        check(tag, 32'({ss_wdat, mem_wdat}), 0);
    endtask

    task automatic fill_save();
        save_sb.delete();
        for (int i = 0; i < 128; i++) save_sb.push_back({1'b0, 10'(i), 1'b0, 7'(i)});
        for (int i = 0; i < 1024; i++) save_sb.push_back({1'b1, 10'(i), 1'b1, 7'(i)});
    endtask

    task automatic fill_restore();
        rest_sb.delete();
        for (int i = 0; i < 127; i++) rest_sb.push_back({1'b0, 10'(i), 8'(i) ^ 8'h5A});
        for (int i = 0; i < 1024; i++) rest_sb.push_back({1'b1, 10'(i), 8'(i) ^ 8'h5A});
    endtask

    int cyc;

    initial begin
        map_rst = 1'b1;
        start   = 1'b0;
        start2  = 1'b0;
        dir     = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        map_rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle must not start anything.
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_idle", 32'({busy, mem_req, ss_act}), 0);

        // Save, with a second start pulsed while busy.
        fill_save();
        snap();
        start2 = 1'b1;
        pulse_start(1'b0);
        start2 = 1'b0;
        repeat (40) @(negedge clk);
        pulse_start(1'b1);
        check("start_while_busy", 32'({busy, ss_act}), 32'b11);
        wait_done(12000, "save_done", cyc);
        @(negedge clk);
        check("save_idle_after", 32'({busy, ss_act, done, err}), 0);
        check("save_write_count", 32'(mem_wr_cnt - b_wr), 1152);
        check("save_buf_07f", 32'(mem_buf[11'h07F]), 32'h7F);
        check("save_buf_405", 32'(mem_buf[11'h405]), 32'h85);
        check("save_done_pulses", 32'(done_cnt - b_done), 1);
        check("save_no_strobes", 32'(stb_cnt - b_stb), 0);
        check("save_sb_drained", 32'(save_sb.size()), 0);
        check("save_act_with_done", 32'(bad_act - b_act), 0);

        cyc = 0;
        while (done2_cnt == 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("lat4_done", 32'(done2_cnt), 1);
        check("lat4_count", 32'(idx2), 1152);
        check("lat4_protocol", 32'(bad2), 0);
        check("lat4_wdat_idle", 32'(ss_wdat2), 0);

        // Full restore.
        for (int a = 0; a < 2048; a++) mem_buf[a] = 8'(a) ^ 8'h5A;
        for (int a = 0; a < 128; a++) map_reg[a] = 8'h00;
        map_reg[127] = 8'hEE;
        fill_restore();
        save_sb.delete();
        snap();
        pulse_start(1'b1);
        wait_done(30000, "restore_done", cyc);
        @(negedge clk);
        check("restore_writes", 32'(map_wr_cnt - b_map), 1151);
        check("restore_strobes", 32'(stb_cnt - b_stb), 1151);
        check("restore_span", 32'(bad_span - b_span), 0);
        check("restore_both_hi", 32'(both_hi - b_both), 0);
        check("restore_ro_reg", 32'(map_reg[127]), 32'hEE);
        check("restore_reg_7e", 32'(map_reg[126]), 32'h7E ^ 32'h5A);
        check("restore_xram_3ff", 32'(map_xram[10'h3FF]), 32'hA5);
        check("restore_sb_drained", 32'(rest_sb.size()), 0);
        check("restore_reads", 32'(mem_rd_cnt - b_rd), 1152);
        check("restore_status", 32'({err, ss_act, done_cnt - b_done}), 1);

        // m2 stuck high: timeout on the very first byte.
        m2_run = 1'b0;
        repeat (20) @(negedge clk);
        snap();
        pulse_start(1'b1);
        wait_done(1000, "timeout_done", cyc);
        check("timeout_latency", 32'(cyc >= 255 && cyc <= 270), 1);
        check("timeout_err", 32'(err), 1);
        check("timeout_at_first", 32'({ss_bank1KB, ss_addr}), 0);
        check("timeout_reads", 32'(mem_rd_cnt - b_rd), 1);
        @(negedge clk);
        check("timeout_idle", 32'({ss_we, ss_wr_req, busy, ss_act, err}), 1);
        check("timeout_done_pulses", 32'(done_cnt - b_done), 1);
        check("timeout_no_write", 32'(map_wr_cnt - b_map), 0);

        // Next start clears err; reset mid-restore at bank 1 addr 0x100.
        m2_run = 1'b1;
        fill_restore();
        snap();
        pulse_start(1'b1);
        @(negedge clk);
        check("start_clears_err", 32'({err, busy}), 1);
        cyc = 0;
        while (!(ss_bank1KB == 8'd1 && ss_addr == 10'h100) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_bank1_100", 32'({ss_bank1KB, ss_addr}), 32'h500);
        map_rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        map_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_no_done", 32'(done_cnt - b_done), 0);
        rest_sb.delete();

        // Restart after reset begins again at bank 0 addr 0.
        fill_save();
        snap();
        pulse_start(1'b0);
        cyc = 0;
        while (!mem_req && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_first_addr", 32'({mem_req, mem_addr}), 32'h800);
        wait_done(12000, "restart_done", cyc);
        @(negedge clk);
        check("restart_write_count", 32'(mem_wr_cnt - b_wr), 1152);
        check("restart_sb_drained", 32'(save_sb.size()), 0);
        check("unexpected_writes", 32'(unexp_mem + unexp_map), 0);
        check("act_with_done", 32'(bad_act), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
